// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//
// Receive end of a servo PWM link. Measures the high time and period of a
// servo pulse train and converts the high time back into a 0..180 degree
// angle without a divider.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   reset_n      synchronous, active-low reset
//   pwm_in       asynchronous servo PWM input
//   angle        last accepted angle, 0..180 (90 after reset)
//   angle_valid  one-cycle strobe when angle is updated
//   locked       high while the most recent frame was fully valid
//   err          one-cycle error strobe
//   err_code     01 width out of range, 10 period out of range, 11 timeout;
//                holds its last value when err is low
//
// Build option:
//   PWM_DEC_GLITCH_FILTER_EN  inserts a 4-cycle stability filter between the
//                             synchronizer and edge detection; pulses or
//                             dropouts of 3 cycles or fewer are ignored.

module servo_pwm_decoder #(
  parameter int unsigned MIN_PULSE   = 50_000,
  parameter int unsigned STEP_CYCLES = 277,
  parameter int unsigned HIGH_MIN    = 45_000,
  parameter int unsigned HIGH_MAX    = 105_000,
  parameter int unsigned PERIOD_MIN  = 900_000,
  parameter int unsigned PERIOD_MAX  = 1_100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       locked,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned CntW = 21;

  localparam logic [CntW-1:0] MinPulseC  = CntW'(MIN_PULSE);
  localparam logic [CntW-1:0] HighMinC   = CntW'(HIGH_MIN);
  localparam logic [CntW-1:0] HighMaxC   = CntW'(HIGH_MAX);
  localparam logic [CntW-1:0] PeriodMinC = CntW'(PERIOD_MIN);
  localparam logic [CntW-1:0] PeriodMaxC = CntW'(PERIOD_MAX);
  localparam logic [CntW-1:0] TimeoutC   = CntW'(PERIOD_MAX + 1);
  localparam logic [8:0]      StepLastC  = 9'(STEP_CYCLES - 1);
  localparam logic [7:0]      AngleMaxC  = 8'd180;

  localparam logic [1:0] CodeWidth   = 2'b01;
  localparam logic [1:0] CodePeriod  = 2'b10;
  localparam logic [1:0] CodeTimeout = 2'b11;

  typedef enum logic [1:0] {StArm, StWaitRise, StHigh, StLow} state_e;

  // Input conditioning
  logic sync1_q, sync2_q;
  logic level;
  logic level_dly_q;
  logic rise, fall;

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] stab_q, stab_d;

  // Level follows sync2 only after it has held a new value for 4 cycles.
  always_comb begin
    filt_d = filt_q;
    stab_d = 2'd0;
    if (sync2_q != filt_q) begin
      if (stab_q == 2'd3) begin
        filt_d = sync2_q;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign rise = level & ~level_dly_q;
  assign fall = ~level & level_dly_q;

  // Decoder state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      presc_q, presc_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      pend_q, pend_d;
  logic [7:0]      angle_q, angle_d;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    angle_d  = angle_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    code_d   = code_q;

    unique case (state_q)
      // Wait for a low level so a pulse already in progress is never decoded.
      StArm: begin
        if (!level) state_d = StWaitRise;
      end

      StWaitRise: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = CntW'(1);
          presc_d = 9'd0;
          acc_d   = 8'd0;
        end
      end

      StHigh: begin
        cnt_d = cnt_q + CntW'(1);
        if (fall) begin
          if (cnt_q >= HighMinC && cnt_q <= HighMaxC) begin
            pend_d  = acc_q;
            state_d = StLow;
          end else begin
            err_d    = 1'b1;
            code_d   = CodeWidth;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = StWaitRise;
          end
        end else if (cnt_q == TimeoutC) begin
          err_d    = 1'b1;
          code_d   = CodeTimeout;
          locked_d = 1'b0;
          cnt_d    = '0;
          state_d  = StArm;
        end else if (cnt_q >= MinPulseC) begin
          // acc_q at the fall equals floor((width - MIN_PULSE) / STEP_CYCLES).
          if (presc_q == StepLastC) begin
            presc_d = 9'd0;
            if (acc_q != AngleMaxC) acc_d = acc_q + 8'd1;
          end else begin
            presc_d = presc_q + 9'd1;
          end
        end
      end

      StLow: begin
        if (rise) begin
          if (cnt_q >= PeriodMinC && cnt_q <= PeriodMaxC) begin
            angle_d  = pend_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            code_d   = CodePeriod;
            locked_d = 1'b0;
          end
          // The closing rise always opens the next frame.
          state_d = StHigh;
          cnt_d   = CntW'(1);
          presc_d = 9'd0;
          acc_d   = 8'd0;
        end else if (cnt_q == TimeoutC) begin
          err_d    = 1'b1;
          code_d   = CodeTimeout;
          locked_d = 1'b0;
          cnt_d    = '0;
          state_d  = StWaitRise;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Synchronizer resets to high: a pulse in progress at reset release then
      // produces no rise, and a low input is just a fall ignored in StArm.
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_dly_q <= 1'b1;
`ifdef PWM_DEC_GLITCH_FILTER_EN
      filt_q      <= 1'b1;
      stab_q      <= 2'd0;
`endif
      state_q     <= StArm;
      cnt_q       <= '0;
      presc_q     <= 9'd0;
      acc_q       <= 8'd0;
      pend_q      <= 8'd0;
      angle_q     <= 8'd90;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      sync1_q     <= pwm_in;
      sync2_q     <= sync1_q;
      level_dly_q <= level;
`ifdef PWM_DEC_GLITCH_FILTER_EN
      filt_q      <= filt_d;
      stab_q      <= stab_d;
`endif
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      angle_q     <= angle_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule
